// File: rtl/hack_screen_scanout.sv
// hack_screen_scanout
//   Scans the 1-bpp Hack screen memory out into an RGB565 LCD raster. The
//   SCREEN_W x SCREEN_H image sits at (X_OFFSET, Y_OFFSET) in LCD coordinates.
//   Each screen word (16 pixels, LSB leftmost) is prefetched 16 pixels before
//   it is needed through a fixed-latency read port. Each bit is then expanded
//   to FG_COLOR / BG_COLOR, optionally swapped by `invert`.
//
//   Optional feature: define HACK_SCANOUT_BORDER_EN to draw a one-pixel
//   BORDER_COLOR frame around the window.
//
// Ports
//   clk, reset        : system clock, synchronous active-high reset
//   pix_ce            : one-clock strobe per LCD pixel
//   de, h_pos, v_pos  : LCD data enable and raster position (valid on pix_ce)
//   invert            : swap FG/BG, sampled per pixel
//   vram_rd_en        : one-clock read request
//   vram_addr         : word address, valid with vram_rd_en, held otherwise
//   vram_rd_data      : read data, valid RD_LAT clocks after vram_rd_en
//   rgb               : registered RGB565 pixel, updates on pix_ce edges
//   underrun          : sticky; a word load found no fresh read data
module hack_screen_scanout #(
    parameter int          SCREEN_W     = 512,
    parameter int          SCREEN_H     = 256,
    parameter int          X_OFFSET     = 144,
    parameter int          Y_OFFSET     = 112,
    parameter int          RD_LAT       = 1,
    parameter logic [15:0] FG_COLOR     = 16'h0000,
    parameter logic [15:0] BG_COLOR     = 16'hFFFF,
    parameter logic [15:0] OUT_COLOR    = 16'h0000,
    parameter logic [15:0] BORDER_COLOR = 16'hF800
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        pix_ce,
    input  logic        de,
    input  logic [9:0]  h_pos,
    input  logic [9:0]  v_pos,
    input  logic        invert,
    output logic        vram_rd_en,
    output logic [12:0] vram_addr,
    input  logic [15:0] vram_rd_data,
    output logic [15:0] rgb,
    output logic        underrun
);

    localparam logic [10:0] SW11    = 11'(SCREEN_W);
    localparam logic [10:0] SH11    = 11'(SCREEN_H);
    localparam logic [10:0] XO11    = 11'(X_OFFSET);
    localparam logic [10:0] YO11    = 11'(Y_OFFSET);
    localparam logic [12:0] WORDS13 = 13'(SCREEN_W / 16);

    // Window-relative coordinates; negative values wrap to large unsigned
    // numbers, so a single unsigned compare covers both window edges.
    logic [10:0] wx, wy, px;
    logic        in_row, in_win, load, fetch, pix_bit, is_border;
    logic [3:0]  bit_idx;
    logic [12:0] fetch_addr;

    logic        vram_rd_en_q, vram_rd_en_d;
    logic [12:0] vram_addr_q,  vram_addr_d;
    logic [15:0] rgb_q,        rgb_d;
    logic        underrun_q,   underrun_d;
    logic [15:0] next_word_q,  next_word_d;
    logic        next_valid_q, next_valid_d;
    logic [15:0] cur_word_q,   cur_word_d;
    // rd_pipe_q[i] is set i clocks after a request; stage RD_LAT marks the
    // cycle in which vram_rd_data carries the answer.
    logic [RD_LAT:1] rd_pipe_q, rd_pipe_d;

    always_comb begin
        wx      = {1'b0, h_pos} - XO11;
        wy      = {1'b0, v_pos} - YO11;
        in_row  = wy < SH11;
        in_win  = in_row && (wx < SW11);
        bit_idx = wx[3:0];
        load    = pix_ce && in_win && (bit_idx == 4'd0);
        // px is the column 16 pixels ahead: word k is fetched when px = 16*k.
        px         = wx + 11'd16;
        fetch      = pix_ce && in_row && (px[3:0] == 4'd0) && (px < SW11);
        fetch_addr = {2'b00, wy} * WORDS13 + {6'd0, px[10:4]};
        // On the load pixel the bit comes straight from next_word, since
        // cur_word only picks it up at this same edge.
        pix_bit = load ? next_word_q[bit_idx] : cur_word_q[bit_idx];
    end

`ifdef HACK_SCANOUT_BORDER_EN
    logic ext_x, ext_y;
    always_comb begin
        ext_x     = (wx <= SW11) || (wx == 11'h7FF);
        ext_y     = (wy <= SH11) || (wy == 11'h7FF);
        is_border = ext_x && ext_y && !in_win;
    end
`else
    logic unused_border;
    assign unused_border = ^BORDER_COLOR;
    assign is_border     = 1'b0;
`endif

    always_comb begin
        rd_pipe_d[1] = vram_rd_en_q;
        for (int i = 2; i <= RD_LAT; i++) begin
            rd_pipe_d[i] = rd_pipe_q[i-1];
        end

        vram_rd_en_d = fetch;
        vram_addr_d  = fetch ? fetch_addr : vram_addr_q;

        next_word_d  = rd_pipe_q[RD_LAT] ? vram_rd_data : next_word_q;
        next_valid_d = next_valid_q;
        if (load)               next_valid_d = 1'b0;
        if (rd_pipe_q[RD_LAT])  next_valid_d = 1'b1;

        cur_word_d = load ? next_word_q : cur_word_q;
        underrun_d = underrun_q | (load && !next_valid_q);

        rgb_d = rgb_q;
        if (pix_ce) begin
            if (!de)            rgb_d = 16'h0000;
            else if (is_border) rgb_d = BORDER_COLOR;
            else if (!in_win)   rgb_d = OUT_COLOR;
            else                rgb_d = (pix_bit ^ invert) ? FG_COLOR : BG_COLOR;
        end
    end

    // Clearing rd_pipe on reset discards any read still in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            vram_rd_en_q <= 1'b0;
            vram_addr_q  <= '0;
            rgb_q        <= '0;
            underrun_q   <= 1'b0;
            next_word_q  <= '0;
            next_valid_q <= 1'b0;
            cur_word_q   <= '0;
            rd_pipe_q    <= '0;
        end else begin
            vram_rd_en_q <= vram_rd_en_d;
            vram_addr_q  <= vram_addr_d;
            rgb_q        <= rgb_d;
            underrun_q   <= underrun_d;
            next_word_q  <= next_word_d;
            next_valid_q <= next_valid_d;
            cur_word_q   <= cur_word_d;
            rd_pipe_q    <= rd_pipe_d;
        end
    end

    assign vram_rd_en = vram_rd_en_q;
    assign vram_addr  = vram_addr_q;
    assign rgb        = rgb_q;
    assign underrun   = underrun_q;

endmodule

// File: tb/tb_hack_screen_scanout.sv
module tb_hack_screen_scanout;
    localparam int SW = 512, SH = 256, XO = 144, YO = 112, RL = 2;
    localparam logic [15:0] FG = 16'h0000, BG = 16'hFFFF, OC = 16'h001F, BC = 16'hF800;

    logic        clk = 0, reset = 1, pix_ce = 0, de = 0, invert = 0;
    logic [9:0]  h_pos = 0, v_pos = 0;
    logic        vram_rd_en, underrun;
    logic [12:0] vram_addr;
    logic [15:0] vram_rd_data, rgb;

    always #5 clk = ~clk;

    hack_screen_scanout #(
        .SCREEN_W(SW), .SCREEN_H(SH), .X_OFFSET(XO), .Y_OFFSET(YO), .RD_LAT(RL),
        .FG_COLOR(FG), .BG_COLOR(BG), .OUT_COLOR(OC), .BORDER_COLOR(BC)
    ) dut (
        .clk(clk), .reset(reset), .pix_ce(pix_ce), .de(de), .h_pos(h_pos), .v_pos(v_pos),
        .invert(invert), .vram_rd_en(vram_rd_en), .vram_addr(vram_addr),
        .vram_rd_data(vram_rd_data), .rgb(rgb), .underrun(underrun)
    );

    // ---------------- screen memory ----------------
    int mem_mode = 0;
    function automatic logic [15:0] mem_word(input int mode, input logic [12:0] a);
        case (mode)
            0:       return 16'h0000;
            1:       return (a == 13'd0) ? 16'h0001 : 16'h0000;
            2:       return 16'hFFFF;
            default: return {a[7:0], ~a[12:5]} ^ 16'h3C5A;
        endcase
    endfunction

    logic [RL-1:0] lat_en = '0;
    logic [12:0]   lat_addr [RL];
    always @(posedge clk) begin
        for (int i = RL - 1; i > 0; i--) begin
            lat_en[i]   <= lat_en[i-1];
            lat_addr[i] <= lat_addr[i-1];
        end
        lat_en[0]   <= vram_rd_en;
        lat_addr[0] <= vram_addr;
    end
    assign vram_rd_data = lat_en[RL-1] ? mem_word(mem_mode, lat_addr[RL-1]) : 16'hDEAD;

    // ---------------- checking ----------------
    int n_chk = 0, n_pass = 0;
    task automatic chk(input string nm, input logic [15:0] got, input logic [15:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", nm, got, exp, $time);
    endtask

    // Behavioural model: pixel colour from window geometry and the screen
    // contents; a word's data is fresh if its read was issued and RL+1 clocks
    // have passed since the qualifying strobe, otherwise the last delivered
    // word is shown again.
    logic [15:0] e_rgb = 0;
    logic [12:0] e_addr = 0;
    bit e_en = 0, e_ur = 0, e_rgb_ok = 1;
    logic [15:0] m_cur = 0, m_last = 0, m_pend = 0;
    bit m_fresh = 0, m_last_ok = 0, m_cur_ok = 1;
    int m_cd = 0;
    bit chk_en = 0;

    always @(posedge clk) begin
        int wx, wy;
        bit inrow, inwin, dnow, bdr;
        if (reset) begin
            e_rgb = 0; e_en = 0; e_addr = 0; e_ur = 0; e_rgb_ok = 1;
            m_cur = 0; m_cur_ok = 1; m_fresh = 0; m_last_ok = 0; m_cd = 0;
        end else begin
            dnow = (m_cd == 1);
            if (m_cd > 0) m_cd--;
            e_en = 0;
            if (pix_ce) begin
                wx = int'(h_pos) - XO;
                wy = int'(v_pos) - YO;
                inrow = (wy >= 0) && (wy < SH);
                inwin = inrow && (wx >= 0) && (wx < SW);
                if (inwin && (wx % 16 == 0)) begin
                    if (m_fresh) begin
                        m_cur = mem_word(mem_mode, 13'(wy * (SW / 16) + wx / 16));
                        m_cur_ok = 1;
                    end else begin
                        e_ur = 1; m_cur = m_last; m_cur_ok = m_last_ok;
                    end
                    m_fresh = 0;
                end
                bdr = 0;
`ifdef HACK_SCANOUT_BORDER_EN
                bdr = !inwin && (wx >= -1) && (wx <= SW) && (wy >= -1) && (wy <= SH);
`endif
                e_rgb_ok = 1;
                if (!de)        e_rgb = 16'h0000;
                else if (bdr)   e_rgb = BC;
                else if (!inwin) e_rgb = OC;
                else begin
                    e_rgb = (m_cur[wx % 16] ^ invert) ? FG : BG;
                    e_rgb_ok = m_cur_ok;
                end
            end
            if (dnow) begin m_fresh = 1; m_last = m_pend; m_last_ok = 1; end
            if (pix_ce && inrow && (wx >= -16) && (wx < SW - 16) && ((wx + 16) % 16 == 0)) begin
                e_en = 1;
                e_addr = 13'(wy * (SW / 16) + (wx + 16) / 16);
                m_cd = RL + 1;
                m_pend = mem_word(mem_mode, e_addr);
            end
        end
    end

    always @(negedge clk) if (chk_en) begin
        if (e_rgb_ok) chk("rgb", rgb, e_rgb);
        chk("underrun", 16'(underrun), 16'(e_ur));
        chk("rd_en", 16'(vram_rd_en), 16'(e_en));
        chk("addr", 16'(vram_addr), 16'(e_addr));
    end

    // Read log: address and the h_pos of the strobe that caused it.
    int req_h = 0;
    logic [12:0] rd_a [$];
    int rd_h [$];
    always @(posedge clk) if (pix_ce) req_h <= int'(h_pos);
    always @(negedge clk) if (vram_rd_en) begin
        rd_a.push_back(vram_addr);
        rd_h.push_back(req_h);
    end

    // ---------------- stimulus ----------------
    logic [15:0] row_rgb [1024];

    task automatic pix(input int h, input int v, input int gap);
        pix_ce = 1; h_pos = 10'(h); v_pos = 10'(v); de = (h < 700);
        @(negedge clk);
        row_rgb[h] = rgb;
        if (gap > 1) begin
            pix_ce = 0;
            repeat (gap - 1) @(negedge clk);
        end
    endtask

    task automatic idle(input int n);
        pix_ce = 0;
        repeat (n) @(negedge clk);
    endtask

    task automatic scan(input int v, input int h0, input int h1, input int gap);
        for (int h = h0; h <= h1; h++) pix(h, v, gap);
        idle(8);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_rgb", rgb, 16'h0000);
        chk("rst_rd_en", 16'(vram_rd_en), 16'h0000);
        chk("rst_addr", 16'(vram_addr), 16'h0000);
        chk("rst_underrun", 16'(underrun), 16'h0000);
        reset = 0;
        chk_en = 1;
        idle(4);

        // all-zero memory
        mem_mode = 0;
        rd_a.delete(); rd_h.delete();
        scan(YO - 2, 120, 200, 4);
        chk("no_reads_above", 16'(rd_a.size()), 16'd0);
        scan(YO - 1, 120, 704, 4);
        scan(YO, 120, 704, 4);
        chk("win_zero", row_rgb[XO + 5], 16'hFFFF);
        chk("outside", row_rgb[XO - 5], OC);
        chk("de_off", row_rgb[702], 16'h0000);
`ifdef HACK_SCANOUT_BORDER_EN
        chk("border_left", row_rgb[XO - 1], BC);
`else
        chk("border_left", row_rgb[XO - 1], OC);
`endif
        chk("beyond_border", row_rgb[XO - 2], OC);
        chk("no_underrun", 16'(underrun), 16'h0000);

        // single set bit at word 0, bit 0
        mem_mode = 1;
        scan(YO, 120, 704, 4);
        chk("px_first", row_rgb[XO], 16'h0000);
        chk("px_second", row_rgb[XO + 1], 16'hFFFF);
        rd_a.delete(); rd_h.delete();
        scan(YO + 1, 120, 704, 4);
        chk("reads_per_row", 16'(rd_a.size()), 16'd32);
        if (rd_a.size() == 32) begin
            chk("addr_w0", 16'(rd_a[0]), 16'd32);
            chk("req_h_w0", 16'(rd_h[0]), 16'(XO - 16));
            chk("addr_w1", 16'(rd_a[1]), 16'd33);
            chk("req_h_w1", 16'(rd_h[1]), 16'(XO));
            chk("addr_w31", 16'(rd_a[31]), 16'd63);
        end

        // invert with all-ones memory, toggled mid-line
        mem_mode = 2;
        invert = 1;
        for (int h = 120; h <= 704; h++) begin
            if (h == 300) invert = 0;
            pix(h, YO + 2, 4);
        end
        idle(8);
        chk("inv_win", row_rgb[XO + 3], 16'hFFFF);
        chk("inv_before", row_rgb[299], 16'hFFFF);
        chk("inv_after", row_rgb[300], 16'h0000);

        // last window row and the row below it
        mem_mode = 3;
        rd_a.delete(); rd_h.delete();
        scan(YO + SH - 1, 120, 704, 4);
        chk("last_row_reads", 16'(rd_a.size()), 16'd32);
        if (rd_a.size() > 0) chk("last_addr", 16'(rd_a[rd_a.size() - 1]), 16'd8191);
        rd_a.delete(); rd_h.delete();
        scan(YO + SH, 120, 704, 4);
        chk("no_reads_below", 16'(rd_a.size()), 16'd0);

        // strobe every clock
        scan(YO + 3, 120, 704, 1);

        // underrun: start a row at the window edge, skipping word-0 prefetch
        scan(YO + 4, 120, 704, 4);
        scan(YO + 5, XO, 300, 4);
        chk("underrun_set", 16'(underrun), 16'h0001);
        scan(YO + 6, 120, 704, 4);
        chk("underrun_sticky", 16'(underrun), 16'h0001);

        // reset right after a prefetch strobe, read still in flight
        for (int h = 120; h < 400; h++) pix(h, YO + 7, 4);
        pix(400, YO + 7, 1);
        pix_ce = 0; reset = 1;
        @(negedge clk);
        chk("mid_rst_rgb", rgb, 16'h0000);
        chk("mid_rst_rd_en", 16'(vram_rd_en), 16'h0000);
        chk("mid_rst_addr", 16'(vram_addr), 16'h0000);
        chk("mid_rst_underrun", 16'(underrun), 16'h0000);
        reset = 0;
        idle(8);
        scan(YO + 8, 120, 704, 4);
        chk("resume_no_underrun", 16'(underrun), 16'h0000);

        idle(4);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
